// File: rtl/ram_arb_pkg.sv
// Shared constants for the RAM port arbiter.
// Widths, RAM latency and bank-select helpers.
package ram_arb_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 10;
  localparam int RAM_RD_LAT = 1;
  localparam int MAX_REQ    = 4;
  localparam int GNT_IDX_W  = 2;
  localparam int BANK_BIT   = ADDR_WIDTH - 1;

  function automatic int bank_bit(input int aw);
    return aw - 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle of the RAM port arbiter.
// Requesters use master, the arbiter uses slave.
interface ram_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;
  logic [NUM_REQ-1:0]            err;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Search starts one past the last granted index.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]   elig,
  input  logic [GNT_IDX_W-1:0] last,
  output logic [NUM_REQ-1:0]   win,
  output logic [GNT_IDX_W-1:0] win_idx,
  output logic                 any
);

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any && elig[i] &&
            ((int'(last) + k) % NUM_REQ) == i) begin
          win[i]  = 1'b1;
          win_idx = GNT_IDX_W'(i);
          any     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among requesters.
// Registered command stage, read tag stage, upper-bank blocking.
module ram_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = ram_arb_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_arb_pkg::ADDR_WIDTH,
  parameter bit BANK1_EN   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_port_arbiter_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  import ram_arb_pkg::*;

  localparam int BB = bank_bit(ADDR_WIDTH);

  logic [NUM_REQ-1:0]    elig, win;
  logic [GNT_IDX_W-1:0]  win_idx;
  logic                  any;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_we, w_bad;

  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    err_q, err_d;
  logic [GNT_IDX_W-1:0]  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  rd_q, rd_d;
  logic                  bad_q, bad_d;
  logic [NUM_REQ-1:0]    rv_q, rv_d;
  logic                  rv_bad_q, rv_bad_d;

  // A requester just granted must re-present before it can win again
  assign elig = bus.req & ~gnt_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .elig    (elig),
    .last    (last_q),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        w_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_we    = bus.req_we[i];
      end
    end
    w_bad = !BANK1_EN && w_addr[BB];
  end

  always_comb begin
    gnt_d    = win;
    err_d    = w_bad ? win : '0;
    last_d   = any ? win_idx : last_q;
    addr_d   = any ? w_addr : addr_q;
    wdata_d  = any ? w_wdata : wdata_q;
    we_d     = any && w_we && !w_bad;
    rd_d     = any && !w_we;
    bad_d    = any && w_bad;
    rv_d     = rd_q ? gnt_q : '0;
    rv_bad_d = bad_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q    <= '0;
      err_q    <= '0;
      last_q   <= GNT_IDX_W'(NUM_REQ - 1);
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rd_q     <= 1'b0;
      bad_q    <= 1'b0;
      rv_q     <= '0;
      rv_bad_q <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      err_q    <= err_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      bad_q    <= bad_d;
      rv_q     <= rv_d;
      rv_bad_q <= rv_bad_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.err    = err_q;
  assign bus.rvalid = rv_q;
  assign bus.rdata  = (|rv_q && !rv_bad_q) ? ram_q : '0;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign ram_we     = we_q;

endmodule
